n64_ctrl_sniffer_mc: RTL and testbench
======================================

Name: n64_ctrl_sniffer_mc

Overview:
Multi-port, parametrised successor to the single-port controller sniffer in the controller subsystem. It passively decodes N64 joybus traffic on up to four controller lines in the CTRL_CLK domain. For each port it captures poll (0x01) and info (0x00/0xFF) responses, validates the stop bit, and tracks controller presence. It hands frames to the NIOS domain through a level/toggle handshake and raises an IGR reset request after a button combo has been held for a programmable number of polls.

Parameters:
NUM_PORTS, 1, number of sniffed controller lines (1..4)
CNT_W, 8, width of the per-port edge-to-edge counter; saturation at all-ones marks line idle
IGR_COMBO, 16'h3030, button pattern on response bits [15:0] that triggers in-game reset
IGR_HOLD, 4, consecutive matching polls required before an IGR request is raised (1..15)

Ports:
CTRL_CLK  in  1  controller sampling clock (4 MHz nominal)
CTRL_RST  in  1  asynchronous, active-high reset
CTRL_i  in  NUM_PORTS  raw joybus lines, asynchronous; bit p = port p
use_igr_i  in  1  IGR enable, already synchronous to CTRL_CLK
tack_i  in  NUM_PORTS  per-port acknowledge toggle from the CPU domain, asynchronous
ctrl_data_o  out  32*NUM_PORTS  last valid poll response per port; slice [32p+31:32p]
info_data_o  out  24*NUM_PORTS  last valid info response per port
new_data_o  out  NUM_PORTS  level: unacknowledged poll frame available
ctrl_detected_o  out  NUM_PORTS  controller responded on the port
frame_err_o  out  8*NUM_PORTS  saturating count of frames rejected for a bad stop bit or truncation
igr_rst_o  out  1  single-cycle IGR reset request

Behaviour:
- Reset: all outputs 0, all channel FSMs in IDLE, edge counters 0, line history all-ones.
- Input conditioning per port: 3-bit shift register; negedge = hist[2]&!hist[1], posedge = !hist[2]&hist[1]. tack_i passes through a 2-flop synchroniser plus an edge register; any change is treated as an ack.
- Bit decode: on posedge, store the counter as low_cnt. On the following negedge, bit = (low_cnt < cnt), i.e. the low phase is shorter than the high phase. Either edge clears the counter; otherwise it increments and saturates.
- Channel FSM:
  - IDLE -> CMD when the counter is saturated and a negedge occurs. Bit and shift registers are cleared.
  - CMD: shift 8 command bits MSB first. On the 9th negedge (console stop bit) decode the command: 0x01 -> RESP with length 32; 0x00 or 0xFF -> RESP with length 24; anything else -> IDLE.
  - RESP: shift response bits MSB first. When the length is reached, the next negedge samples the stop bit. Stop bit = 1 -> commit the frame and go to IDLE. Stop bit = 0 -> frame_err +1 and go to IDLE.
  - Any state other than IDLE: counter saturation aborts to IDLE. In RESP with at least 1 bit received, the abort also increments frame_err.
  - Commit latency: ctrl_data_o / info_data_o update on the cycle after the stop-bit negedge is detected.
- Presence: ctrl_detected set on any commit. It is cleared when a CMD 0x01 stop bit is followed by saturation with no response bits.
- Handshake: a poll commit sets new_data. A tack edge clears it. If both occur in the same cycle, set wins. ctrl_data_o is stable while new_data = 1 unless a newer commit overwrites it.
- IGR: per-port hold counter (4 bits). On a poll commit, if data[15:0] == IGR_COMBO the counter increments (saturating at IGR_HOLD); otherwise it clears. igr_rst_o pulses for 1 cycle when use_igr_i = 1 and any counter reaches IGR_HOLD, then that counter clears. With use_igr_i = 0 counters still track, but no pulse is produced.
- Reset asserted mid-frame: immediate return to reset values; partial data is discarded.

Decomposition:
- Shared package (n64adv2_ctrl_pkg.vh): command codes 0x00/0x01/0xFF, response lengths 24/32, default IGR_COMBO, channel FSM state encodings.
- Sub-module n64_ctrl_chan_rx: one per port via generate. It holds the edge detect, bit decode, FSM, data/info registers, frame_err and hold counter.
- The top level contains the tack synchronisers, handshake and IGR OR-reduction.

Test Plan:
- 1 port, idle 80 us, command 0x01 + stop, response 0x12345678 + stop 1 -> ctrl_data_o = 0x12345678, new_data_o = 1 one cycle after the stop negedge, ctrl_detected_o = 1, frame_err_o = 0.
- Command 0x00, response 0x050002 -> info_data_o = 0x050002; ctrl_data_o and new_data_o unchanged.
- Poll response with stop bit 0 -> data unchanged, frame_err_o = 1. Response truncated after 20 bits -> frame_err_o = 2.
- 4 ports, simultaneous polls with distinct data; toggle tack_i[2] in the same cycle as the port-2 commit -> all four slices correct, new_data_o = 4'b1111 (set wins); the next tack_i[2] toggle -> 4'b1011.
- use_igr_i = 1, port 1 returns 0x00003030 for 4 polls -> exactly one igr_rst_o pulse after the 4th commit. Repeat with a non-matching 3rd poll -> no pulse until 4 consecutive matches.
- Assert CTRL_RST during RESP bit 10 -> all outputs 0; the next complete frame decodes correctly.

Source files
------------

// File: rtl/n64adv2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n64adv2_ctrl_pkg
// Description : Shared joybus constants, channel FSM states and a helper
//               that maps a console command to its response length.
// Revision    : 1.0 - initial multi-port release
// ============================================================================
package n64adv2_ctrl_pkg;

  localparam logic [7:0]  CMD_INFO          = 8'h00;
  localparam logic [7:0]  CMD_POLL          = 8'h01;
  localparam logic [7:0]  CMD_RESET         = 8'hFF;
  localparam logic [5:0]  LEN_INFO          = 6'd24;
  localparam logic [5:0]  LEN_POLL          = 6'd32;
  localparam logic [15:0] IGR_COMBO_DEFAULT = 16'h3030;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_CMD  = 2'd1,
    CH_RESP = 2'd2
  } chan_state_t;

  // Response length for a console command; zero means "not a command we follow".
  function automatic logic [5:0] cmd_resp_len(input logic [7:0] cmd);
    logic [5:0] len;
    len = 6'd0;
    if (cmd == CMD_POLL) len = LEN_POLL;
    else if (cmd == CMD_INFO || cmd == CMD_RESET) len = LEN_INFO;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/n64_ctrl_chan_rx.sv
`default_nettype none
// ============================================================================
// Module      : n64_ctrl_chan_rx
// Description : One joybus sniffer channel: line conditioning, pulse-width
//               bit decode, command/response FSM, captured frames, frame
//               error counter and IGR hold counter.
// Revision    : 1.0 - initial multi-port release
// ============================================================================
module n64_ctrl_chan_rx
  import n64adv2_ctrl_pkg::*;
#(
  parameter int          CNT_W     = 8,
  parameter logic [15:0] IGR_COMBO = IGR_COMBO_DEFAULT,
  parameter int          IGR_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line,
  input  logic        use_igr,
  output logic        poll_commit,
  output logic [31:0] ctrl_data,
  output logic [23:0] info_data,
  output logic        detected,
  output logic [7:0]  frame_err,
  output logic        igr_hit
);

  localparam logic [3:0] HOLD_MAX = 4'(IGR_HOLD);

  logic [2:0]       hist;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             neg_edge;
  logic             pos_edge;
  logic             cnt_sat;
  logic             bit_val;

  chan_state_t      state;
  chan_state_t      state_nxt;
  logic [31:0]      sr;
  logic [5:0]       bit_cnt;
  logic [5:0]       resp_len;
  logic [5:0]       len_dec;
  logic             is_poll;
  logic             started;
  logic [3:0]       hold;
  logic [3:0]       hold_base;

  logic             start_frame;
  logic             shift_en;
  logic             cmd_done;
  logic             resp_mark;
  logic             commit;
  logic             err_inc;
  logic             lost;

  assign neg_edge  = hist[2] & ~hist[1];
  assign pos_edge  = ~hist[2] & hist[1];
  assign cnt_sat   = &cnt;
  assign bit_val   = (low_cnt < cnt);
  assign len_dec   = cmd_resp_len({sr[6:0], bit_val});
  assign igr_hit   = use_igr && (hold == HOLD_MAX);
  assign hold_base = igr_hit ? 4'd0 : hold;
  assign poll_commit = commit & is_poll;

  // Line history and edge-to-edge timing; the low phase length is latched on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= 3'b111;
      cnt     <= '0;
      low_cnt <= '0;
    end else begin
      hist <= {hist[1:0], line};
      if (neg_edge || pos_edge) cnt <= '0;
      else if (!cnt_sat)        cnt <= cnt + CNT_W'(1);
      if (pos_edge) low_cnt <= cnt;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CH_IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes; every bit cell is decoded on the falling edge that ends it.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    cmd_done    = 1'b0;
    resp_mark   = 1'b0;
    commit      = 1'b0;
    err_inc     = 1'b0;
    lost        = 1'b0;
    case (state)
      CH_IDLE: begin
        if (neg_edge && cnt_sat) begin
          state_nxt   = CH_CMD;
          start_frame = 1'b1;
        end
      end
      CH_CMD: begin
        if (neg_edge) begin
          shift_en = 1'b1;
          if (bit_cnt == 6'd7) begin
            // This edge also starts the console stop bit.
            cmd_done  = 1'b1;
            state_nxt = (len_dec != 6'd0) ? CH_RESP : CH_IDLE;
          end
        end else if (cnt_sat) begin
          state_nxt = CH_IDLE;
        end
      end
      CH_RESP: begin
        if (neg_edge) begin
          if (!started) begin
            // Ends the console stop bit and opens the first response cell.
            resp_mark = 1'b1;
          end else if (bit_cnt != resp_len) begin
            shift_en = 1'b1;
          end else begin
            state_nxt = CH_IDLE;
            if (bit_val) commit  = 1'b1;
            else         err_inc = 1'b1;
          end
        end else if (cnt_sat) begin
          state_nxt = CH_IDLE;
          if (bit_cnt != 6'd0)     err_inc = 1'b1;
          if (!started && is_poll) lost    = 1'b1;
        end
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  // Shift register, bit counter and command bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      resp_len <= '0;
      is_poll  <= 1'b0;
      started  <= 1'b0;
    end else begin
      if (start_frame || cmd_done) begin
        sr      <= '0;
        bit_cnt <= '0;
        started <= 1'b0;
      end else if (shift_en) begin
        sr      <= {sr[30:0], bit_val};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (cmd_done) begin
        resp_len <= len_dec;
        is_poll  <= ({sr[6:0], bit_val} == CMD_POLL);
      end
      if (resp_mark) started <= 1'b1;
    end
  end

  // Committed frames, presence, saturating error count and IGR hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_data <= '0;
      info_data <= '0;
      detected  <= 1'b0;
      frame_err <= '0;
      hold      <= '0;
    end else begin
      if (commit) begin
        if (is_poll) ctrl_data <= sr;
        else         info_data <= sr[23:0];
      end
      if (commit)    detected <= 1'b1;
      else if (lost) detected <= 1'b0;
      if (err_inc && frame_err != 8'hFF) frame_err <= frame_err + 8'd1;
      if (poll_commit) begin
        if (sr[15:0] == IGR_COMBO)
          hold <= (hold_base == HOLD_MAX) ? HOLD_MAX : hold_base + 4'd1;
        else
          hold <= 4'd0;
      end else if (igr_hit) begin
        hold <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/n64_ctrl_sniffer_mc.sv
`default_nettype none
// ============================================================================
// Module      : n64_ctrl_sniffer_mc
// Description : Multi-port passive joybus sniffer. One receive channel per
//               port, acknowledge synchronisers, new-data handshake and the
//               combined in-game-reset request.
// Revision    : 1.0 - initial multi-port release
// ============================================================================
module n64_ctrl_sniffer_mc
  import n64adv2_ctrl_pkg::*;
#(
  parameter int          NUM_PORTS = 1,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] IGR_COMBO = IGR_COMBO_DEFAULT,
  parameter int          IGR_HOLD  = 4
) (
  input  logic                   CTRL_CLK,
  input  logic                   CTRL_RST,
  input  logic [NUM_PORTS-1:0]   CTRL_i,
  input  logic                   use_igr_i,
  input  logic [NUM_PORTS-1:0]   tack_i,
  output logic [32*NUM_PORTS-1:0] ctrl_data_o,
  output logic [24*NUM_PORTS-1:0] info_data_o,
  output logic [NUM_PORTS-1:0]   new_data_o,
  output logic [NUM_PORTS-1:0]   ctrl_detected_o,
  output logic [8*NUM_PORTS-1:0] frame_err_o,
  output logic                   igr_rst_o
);

  logic [NUM_PORTS-1:0] poll_commit;
  logic [NUM_PORTS-1:0] igr_hit;
  logic [NUM_PORTS-1:0] tack_s1;
  logic [NUM_PORTS-1:0] tack_s2;
  logic [NUM_PORTS-1:0] tack_s3;
  logic [NUM_PORTS-1:0] ack;

  assign ack = tack_s2 ^ tack_s3;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    n64_ctrl_chan_rx #(
      .CNT_W     (CNT_W),
      .IGR_COMBO (IGR_COMBO),
      .IGR_HOLD  (IGR_HOLD)
    ) u_chan (
      .clk         (CTRL_CLK),
      .rst         (CTRL_RST),
      .line        (CTRL_i[p]),
      .use_igr     (use_igr_i),
      .poll_commit (poll_commit[p]),
      .ctrl_data   (ctrl_data_o[32*p +: 32]),
      .info_data   (info_data_o[24*p +: 24]),
      .detected    (ctrl_detected_o[p]),
      .frame_err   (frame_err_o[8*p +: 8]),
      .igr_hit     (igr_hit[p])
    );
  end

  // Bring the CPU acknowledge toggles into this domain; the third stage exposes the change.
  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      tack_s1 <= '0;
      tack_s2 <= '0;
      tack_s3 <= '0;
    end else begin
      tack_s1 <= tack_i;
      tack_s2 <= tack_s1;
      tack_s3 <= tack_s2;
    end
  end

  // New-data level per port: a poll commit sets it and outranks a simultaneous acknowledge.
  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) new_data_o <= '0;
    else          new_data_o <= (new_data_o & ~ack) | poll_commit;
  end

  // One-cycle IGR request whenever any port's hold counter completes.
  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) igr_rst_o <= 1'b0;
    else          igr_rst_o <= |igr_hit;
  end

endmodule
`default_nettype wire

// File: tb/tb_n64_ctrl_sniffer_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_n64_ctrl_sniffer_mc
// Description : Self-checking bench for the 4-port joybus sniffer: directed
//               frame table, multi-port handshake, IGR sequences, random
//               rounds against a frame-level model, and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_ctrl_sniffer_mc;

  localparam int          NP      = 4;
  localparam int          T_SHORT = 4;
  localparam int          T_LONG  = 12;
  localparam int          GAP     = 8;
  localparam int          TAIL    = 300;
  localparam int          HOLD    = 4;
  localparam logic [15:0] COMBO   = 16'h3030;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     ctrl_line;
  logic              use_igr;
  logic [NP-1:0]     tack;
  logic [32*NP-1:0]  ctrl_data;
  logic [24*NP-1:0]  info_data;
  logic [NP-1:0]     new_data;
  logic [NP-1:0]     detected;
  logic [8*NP-1:0]   frame_err;
  logic              igr_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_pulses = 0;

  logic [31:0] m_ctrl [NP];
  logic [23:0] m_info [NP];
  logic        m_new  [NP];
  logic        m_det  [NP];
  logic [7:0]  m_err  [NP];
  int          m_hold [NP];
  int          m_pulses = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] resp;
    int          nbits;
    logic        stop;
    logic        ack;
    logic [31:0] exp_ctrl;
    logic [23:0] exp_info;
    logic        exp_new;
    logic        exp_det;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vec [9];

  n64_ctrl_sniffer_mc #(
    .NUM_PORTS (NP),
    .CNT_W     (8),
    .IGR_COMBO (COMBO),
    .IGR_HOLD  (HOLD)
  ) dut (
    .CTRL_CLK        (clk),
    .CTRL_RST        (rst),
    .CTRL_i          (ctrl_line),
    .use_igr_i       (use_igr),
    .tack_i          (tack),
    .ctrl_data_o     (ctrl_data),
    .info_data_o     (info_data),
    .new_data_o      (new_data),
    .ctrl_detected_o (detected),
    .frame_err_o     (frame_err),
    .igr_rst_o       (igr_rst)
  );

  always #5 clk = ~clk;

  // Count high cycles of the IGR request, sampled away from the active edge.
  always @(negedge clk) if (!rst && igr_rst === 1'b1) seen_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_len(input logic [7:0] c);
    if (c == 8'h01) return 32;
    if (c == 8'h00 || c == 8'hFF) return 24;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_ctrl[p] = '0; m_info[p] = '0; m_new[p] = 1'b0;
      m_det[p] = 1'b0; m_err[p] = '0; m_hold[p] = 0;
    end
  endfunction

  // Frame-level outcome: nbits is the number of response cells the controller sent.
  function automatic void model_frame(input int p, input logic [7:0] cmd, input logic [31:0] resp,
                                      input int nbits, input logic stop);
    int len;
    len = model_len(cmd);
    if (len == 0) return;
    if (nbits == 0) begin
      if (len == 32) m_det[p] = 1'b0;
      return;
    end
    if (nbits < len || !stop) begin
      if (m_err[p] != 8'hFF) m_err[p] = m_err[p] + 8'd1;
      return;
    end
    m_det[p] = 1'b1;
    if (len == 32) begin
      m_ctrl[p] = resp;
      m_new[p]  = 1'b1;
      if (resp[15:0] == COMBO) m_hold[p] = (m_hold[p] + 1 > HOLD) ? HOLD : m_hold[p] + 1;
      else                     m_hold[p] = 0;
    end else begin
      m_info[p] = resp[23:0];
    end
  endfunction

  function automatic void model_igr();
    bit any;
    any = 1'b0;
    if (use_igr) begin
      for (int p = 0; p < NP; p++) begin
        if (m_hold[p] == HOLD) begin
          any = 1'b1;
          m_hold[p] = 0;
        end
      end
    end
    if (any) m_pulses++;
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s ctrl[%0d]", tag, p), ctrl_data[32*p +: 32], m_ctrl[p]);
      chk($sformatf("%s info[%0d]", tag, p), {8'h0, info_data[24*p +: 24]}, {8'h0, m_info[p]});
      chk($sformatf("%s new[%0d]", tag, p), {31'h0, new_data[p]}, {31'h0, m_new[p]});
      chk($sformatf("%s det[%0d]", tag, p), {31'h0, detected[p]}, {31'h0, m_det[p]});
      chk($sformatf("%s err[%0d]", tag, p), {24'h0, frame_err[8*p +: 8]}, {24'h0, m_err[p]});
    end
    chk({tag, " igr_pulses"}, seen_pulses, m_pulses);
  endtask

  task automatic drive_cell(input int p, input logic b);
    ctrl_line[p] = 1'b0;
    repeat (b ? T_SHORT : T_LONG) @(negedge clk);
    ctrl_line[p] = 1'b1;
    repeat (b ? T_LONG : T_SHORT) @(negedge clk);
  endtask

  // Command, console stop, nbits response cells, then the device stop cell closed by a falling edge.
  task automatic send_frame(input int p, input logic [7:0] cmd, input logic [31:0] resp,
                            input int nbits, input logic stop, input bit lat_chk, input bit tack_tog);
    int len;
    int w;
    len = model_len(cmd);
    w = (len == 0) ? 32 : len;
    for (int i = 7; i >= 0; i--) drive_cell(p, cmd[i]);
    ctrl_line[p] = 1'b0;
    repeat (T_SHORT) @(negedge clk);
    ctrl_line[p] = 1'b1;
    repeat (T_LONG + GAP) @(negedge clk);
    for (int i = 0; i < nbits; i++) drive_cell(p, resp[w-1-i]);
    if (len != 0 && nbits == len) begin
      drive_cell(p, stop);
      ctrl_line[p] = 1'b0;
      if (tack_tog) tack[p] = ~tack[p];
      if (lat_chk) begin
        @(posedge clk); @(posedge clk); #1;
        chk("latency new early", {31'h0, new_data[p]}, 32'h0);
        @(posedge clk); #1;
        chk("latency new", {31'h0, new_data[p]}, 32'h1);
        chk("latency ctrl", ctrl_data[32*p +: 32], resp);
        @(negedge clk);
      end else begin
        repeat (T_SHORT) @(negedge clk);
      end
      ctrl_line[p] = 1'b1;
    end
    repeat (TAIL) @(negedge clk);
  endtask

  task automatic toggle_ack(input int p);
    tack[p] = ~tack[p];
    m_new[p] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (TAIL) @(negedge clk);
  endtask

  logic [7:0]  fc [NP];
  logic [31:0] fr [NP];
  int          fn [NP];
  logic        fs [NP];

  initial begin
    //           cmd    resp          nb  stop ack   exp_ctrl      exp_info   new   det   err
    vec[0] = '{8'h01, 32'h12345678, 32, 1'b1, 1'b0, 32'h12345678, 24'h000000, 1'b1, 1'b1, 8'd0};
    vec[1] = '{8'h00, 32'h00050002, 24, 1'b1, 1'b0, 32'h12345678, 24'h050002, 1'b1, 1'b1, 8'd0};
    vec[2] = '{8'h01, 32'hDEADBEEF, 32, 1'b0, 1'b0, 32'h12345678, 24'h050002, 1'b1, 1'b1, 8'd1};
    vec[3] = '{8'h01, 32'hA5A5A5A5, 20, 1'b1, 1'b0, 32'h12345678, 24'h050002, 1'b1, 1'b1, 8'd2};
    vec[4] = '{8'hFF, 32'h00ABCDEF, 24, 1'b1, 1'b1, 32'h12345678, 24'hABCDEF, 1'b0, 1'b1, 8'd2};
    vec[5] = '{8'h01, 32'h00000000,  0, 1'b1, 1'b0, 32'h12345678, 24'hABCDEF, 1'b0, 1'b0, 8'd2};
    vec[6] = '{8'h02, 32'hFF00FF00,  8, 1'b1, 1'b0, 32'h12345678, 24'hABCDEF, 1'b0, 1'b0, 8'd2};
    vec[7] = '{8'h01, 32'hCAFE0001, 32, 1'b1, 1'b0, 32'hCAFE0001, 24'hABCDEF, 1'b1, 1'b1, 8'd2};
    vec[8] = '{8'h01, 32'h00000000,  0, 1'b1, 1'b0, 32'hCAFE0001, 24'hABCDEF, 1'b1, 1'b0, 8'd2};

    rst = 1'b1;
    ctrl_line = '1;
    use_igr = 1'b0;
    tack = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (TAIL) @(negedge clk);

    // Directed frame table on port 0.
    for (int i = 0; i < 9; i++) begin
      if (vec[i].ack) toggle_ack(0);
      send_frame(0, vec[i].cmd, vec[i].resp, vec[i].nbits, vec[i].stop, (i == 0), 1'b0);
      model_frame(0, vec[i].cmd, vec[i].resp, vec[i].nbits, vec[i].stop);
      chk($sformatf("vec%0d ctrl", i), ctrl_data[31:0], vec[i].exp_ctrl);
      chk($sformatf("vec%0d info", i), {8'h0, info_data[23:0]}, {8'h0, vec[i].exp_info});
      chk($sformatf("vec%0d new", i), {31'h0, new_data[0]}, {31'h0, vec[i].exp_new});
      chk($sformatf("vec%0d det", i), {31'h0, detected[0]}, {31'h0, vec[i].exp_det});
      chk($sformatf("vec%0d err", i), {24'h0, frame_err[7:0]}, {24'h0, vec[i].exp_err});
    end
    check_all("table");

    // Four simultaneous polls; port 2 is acknowledged in its commit cycle.
    fr[0] = 32'h01020304; fr[1] = 32'h0A0B0C0D; fr[2] = 32'h55AA55AA; fr[3] = 32'h80000001;
    fork
      send_frame(0, 8'h01, fr[0], 32, 1'b1, 1'b0, 1'b0);
      send_frame(1, 8'h01, fr[1], 32, 1'b1, 1'b0, 1'b0);
      send_frame(2, 8'h01, fr[2], 32, 1'b1, 1'b0, 1'b1);
      send_frame(3, 8'h01, fr[3], 32, 1'b1, 1'b0, 1'b0);
    join
    for (int p = 0; p < NP; p++) model_frame(p, 8'h01, fr[p], 32, 1'b1);
    chk("set wins new", {28'h0, new_data}, 32'hF);
    check_all("4port");
    toggle_ack(2);
    chk("ack port2 new", {28'h0, new_data}, 32'hB);
    check_all("4port ack");

    // IGR: four matching polls, then a run broken by a non-matching third poll.
    do_reset();
    use_igr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_frame(1, 8'h01, 32'h00003030, 32, 1'b1, 1'b0, 1'b0);
      model_frame(1, 8'h01, 32'h00003030, 32, 1'b1);
      model_igr();
      chk($sformatf("igr run A poll%0d", i), seen_pulses, (i == 3) ? 1 : 0);
    end
    for (int i = 0; i < 7; i++) begin
      fr[1] = (i == 2) ? 32'h00001234 : 32'h00003030;
      send_frame(1, 8'h01, fr[1], 32, 1'b1, 1'b0, 1'b0);
      model_frame(1, 8'h01, fr[1], 32, 1'b1);
      model_igr();
      chk($sformatf("igr run B poll%0d", i), seen_pulses, (i == 6) ? 2 : 1);
    end
    check_all("igr");

    // Random rounds on all ports, checked against the frame-level model.
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < NP; p++) if ($urandom_range(0, 2) == 0) toggle_ack(p);
      for (int p = 0; p < NP; p++) begin
        fr[p] = $urandom;
        fs[p] = 1'b1;
        case ($urandom_range(0, 5))
          0, 1: begin
            fc[p] = 8'h01; fn[p] = 32;
            if ($urandom_range(0, 1) == 1) fr[p][15:0] = COMBO;
          end
          2: begin fc[p] = 8'h01; fn[p] = 32; fs[p] = 1'b0; end
          3: begin fc[p] = 8'h01; fn[p] = $urandom_range(2, 31); end
          4: begin fc[p] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF; fn[p] = 24; end
          default: begin
            if ($urandom_range(0, 1) == 1) begin fc[p] = 8'h01; fn[p] = 0; end
            else begin fc[p] = 8'($urandom_range(2, 254)); fn[p] = 8; end
          end
        endcase
      end
      fork
        send_frame(0, fc[0], fr[0], fn[0], fs[0], 1'b0, 1'b0);
        send_frame(1, fc[1], fr[1], fn[1], fs[1], 1'b0, 1'b0);
        send_frame(2, fc[2], fr[2], fn[2], fs[2], 1'b0, 1'b0);
        send_frame(3, fc[3], fr[3], fn[3], fs[3], 1'b0, 1'b0);
      join
      for (int p = 0; p < NP; p++) model_frame(p, fc[p], fr[p], fn[p], fs[p]);
      model_igr();
      check_all($sformatf("rand%0d", r));
    end

    // Reset asserted during response bit 10, then a clean frame.
    fork
      send_frame(0, 8'h01, 32'h87654321, 32, 1'b1, 1'b0, 1'b0);
      begin
        repeat (8 * 16 + T_SHORT + T_LONG + GAP + 10 * 16 + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst ctrl", ctrl_data[31:0] | ctrl_data[63:32] | ctrl_data[95:64] | ctrl_data[127:96], 32'h0);
        chk("midrst info", {8'h0, info_data[23:0] | info_data[47:24] | info_data[71:48] | info_data[95:72]}, 32'h0);
        chk("midrst flags", {new_data, detected, frame_err, 1'b0, igr_rst}, 48'h0);
        rst = 1'b0;
        model_reset();
      end
    join
    check_all("after midrst");
    send_frame(0, 8'h01, 32'h0F1E2D3C, 32, 1'b1, 1'b0, 1'b0);
    model_frame(0, 8'h01, 32'h0F1E2D3C, 32, 1'b1);
    model_igr();
    check_all("post reset frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
